// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: E-stage forwarding selects, load-use and
// long-latency scoreboard stalls, branch flushes, and outstanding-op accounting.
module hazard_scoreboard_unit #(
  parameter int AW     = 5,
  parameter int NPORTS = 2,
  parameter int MAX_MC = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORTS*AW-1:0]         rs_D,
  input  logic [AW-1:0]                rd_D,
  input  logic                         regwrite_D,
  input  logic                         mc_op_D,
  input  logic [NPORTS*AW-1:0]         rs_E,
  input  logic [AW-1:0]                rd_E,
  input  logic                         regwrite_E,
  input  logic                         load_E,
  input  logic                         mc_issue_E,
  input  logic                         pcsrc_E,
  input  logic [AW-1:0]                rd_M,
  input  logic                         regwrite_M,
  input  logic [AW-1:0]                rd_W,
  input  logic                         regwrite_W,
  input  logic                         mc_done,
  input  logic [AW-1:0]                mc_rd,
  output logic [2*NPORTS-1:0]          forward_E,
  output logic                         stall_F,
  output logic                         stall_D,
  output logic                         flush_D,
  output logic                         flush_E,
  output logic [$clog2(MAX_MC+1)-1:0]  mc_count
);

  localparam int NREG = 1 << AW;
  localparam int CW   = $clog2(MAX_MC + 1);
  localparam logic [CW:0]   MAX_MC_W = (CW+1)'(MAX_MC);
  localparam logic [CW-1:0] MC_FULL  = CW'(MAX_MC);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   count_nxt;
  logic            issue_trk;
  logic            done_vld;
  logic            load_use;
  logic            issue_hit;
  logic            sb_hit;
  logic            cap_hit;
  logic            hazard;

  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] rs,
    input logic [AW-1:0] dst_m,
    input logic          wr_m,
    input logic [AW-1:0] dst_w,
    input logic          wr_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && wr_m && rs == dst_m)
      sel = 2'b10;
    else if (rs != '0 && wr_w && rs == dst_w)
      sel = 2'b01;
    return sel;
  endfunction

  function automatic logic src_match(
    input logic [AW-1:0]        a,
    input logic [NPORTS*AW-1:0] rs
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NPORTS; p++)
      if (a != '0 && a == rs[p*AW +: AW])
        hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    forward_E = '0;
    for (int p = 0; p < NPORTS; p++)
      forward_E[2*p +: 2] = fwd_sel(rs_E[p*AW +: AW], rd_M, regwrite_M, rd_W, regwrite_W);
  end

  always_comb begin
    load_use  = load_E && regwrite_E && src_match(rd_E, rs_D);
    // An op issuing this cycle has not reached the busy bits yet, so match it directly.
    issue_hit = mc_issue_E &&
                (src_match(rd_E, rs_D) || (regwrite_D && rd_E != '0 && rd_D == rd_E));
    sb_hit    = regwrite_D && rd_D != '0 && busy[rd_D];
    for (int p = 0; p < NPORTS; p++)
      if (rs_D[p*AW +: AW] != '0 && busy[rs_D[p*AW +: AW]])
        sb_hit = 1'b1;
    cap_hit   = mc_op_D && (({1'b0, mc_count} + {{CW{1'b0}}, mc_issue_E}) >= MAX_MC_W);
    hazard    = load_use || issue_hit || sb_hit || cap_hit;
  end

  // A taken branch squashes the D instruction, so its hazards are moot.
  assign stall_D = hazard && !pcsrc_E;
  assign stall_F = stall_D;
  assign flush_D = pcsrc_E;
  assign flush_E = pcsrc_E || stall_D;

  always_comb begin
    issue_trk = mc_issue_E && rd_E != '0;
    done_vld  = mc_done && busy[mc_rd];
    busy_nxt  = busy;
    if (done_vld)
      busy_nxt[mc_rd] = 1'b0;
    if (issue_trk)
      busy_nxt[rd_E] = 1'b1;
    count_nxt = mc_count;
    if (issue_trk && !done_vld && mc_count != MC_FULL)
      count_nxt = mc_count + CW'(1);
    else if (!issue_trk && done_vld && mc_count != '0)
      count_nxt = mc_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      mc_count <= '0;
    end else begin
      busy     <= busy_nxt;
      mc_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rs_D, rs_E;
  logic [4:0] rd_D, rd_E, rd_M, rd_W, mc_rd;
  logic       regwrite_D, mc_op_D, regwrite_E, load_E, mc_issue_E, pcsrc_E;
  logic       regwrite_M, regwrite_W, mc_done;
  logic [3:0] forward_E;
  logic       stall_F, stall_D, flush_D, flush_E;
  logic [2:0] mc_count;

  int tests = 0;
  int fails = 0;
  int q[$];  // destinations of outstanding long-latency ops

  hazard_scoreboard_unit #(.AW(5), .NPORTS(2), .MAX_MC(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rd_D(rd_D), .regwrite_D(regwrite_D), .mc_op_D(mc_op_D),
    .rs_E(rs_E), .rd_E(rd_E), .regwrite_E(regwrite_E), .load_E(load_E),
    .mc_issue_E(mc_issue_E), .pcsrc_E(pcsrc_E),
    .rd_M(rd_M), .regwrite_M(regwrite_M), .rd_W(rd_W), .regwrite_W(regwrite_W),
    .mc_done(mc_done), .mc_rd(mc_rd),
    .forward_E(forward_E), .stall_F(stall_F), .stall_D(stall_D),
    .flush_D(flush_D), .flush_E(flush_E), .mc_count(mc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int a);
    bit f = 1'b0;
    for (int i = 0; i < q.size(); i++)
      if (q[i] == a) f = 1'b1;
    return f;
  endfunction

  function automatic int exp_fwd();
    int res = 0;
    for (int p = 0; p < 2; p++) begin
      int r = int'(rs_E[p*5 +: 5]);
      int sel = 0;
      if (r != 0 && regwrite_M && r == int'(rd_M)) sel = 2;
      else if (r != 0 && regwrite_W && r == int'(rd_W)) sel = 1;
      res += sel << (2*p);
    end
    return res;
  endfunction

  function automatic int exp_stall();
    bit hz = 1'b0;
    for (int p = 0; p < 2; p++) begin
      int r = int'(rs_D[p*5 +: 5]);
      if (r != 0) begin
        if (load_E && regwrite_E && r == int'(rd_E)) hz = 1'b1;
        if (mc_issue_E && r == int'(rd_E)) hz = 1'b1;
        if (m_busy(r)) hz = 1'b1;
      end
    end
    if (regwrite_D && rd_D != 0) begin
      if (mc_issue_E && rd_D == rd_E) hz = 1'b1;
      if (m_busy(int'(rd_D))) hz = 1'b1;
    end
    if (mc_op_D && (q.size() + int'(mc_issue_E) >= 4)) hz = 1'b1;
    return (hz && !pcsrc_E) ? 1 : 0;
  endfunction

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n) begin
      if (mc_done)
        for (int i = 0; i < q.size(); i++)
          if (q[i] == int'(mc_rd)) begin
            q.delete(i);
            break;
          end
      if (mc_issue_E && rd_E != 0) q.push_back(int'(rd_E));
    end
  end

  always @(negedge clk) begin
    int s;
    s = exp_stall();
    chk("m_fwd", int'(forward_E), exp_fwd());
    chk("m_stall_F", int'(stall_F), s);
    chk("m_stall_D", int'(stall_D), s);
    chk("m_flush_D", int'(flush_D), int'(pcsrc_E));
    chk("m_flush_E", int'(flush_E), (pcsrc_E || s != 0) ? 1 : 0);
    chk("m_count", int'(mc_count), q.size());
  end

  task automatic idle();
    rs_D = '0; rd_D = '0; regwrite_D = 1'b0; mc_op_D = 1'b0;
    rs_E = '0; rd_E = '0; regwrite_E = 1'b0; load_E = 1'b0;
    mc_issue_E = 1'b0; pcsrc_E = 1'b0;
    rd_M = '0; regwrite_M = 1'b0; rd_W = '0; regwrite_W = 1'b0;
    mc_done = 1'b0; mc_rd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(mc_count), 0);
    chk("rst_fwd", int'(forward_E), 0);
    chk("rst_stall", int'(stall_D), 0);
    chk("rst_flush", int'(flush_E), 0);
    rst_n = 1'b1;

    step(); rs_E = {5'd5, 5'd5}; rd_M = 5'd5; rd_W = 5'd5; regwrite_M = 1'b1; regwrite_W = 1'b1;
    #1 chk("fwd_m_prio", int'(forward_E), 'b1010);
    step(); regwrite_M = 1'b0;
    #1 chk("fwd_w", int'(forward_E), 'b0101);
    step(); rs_E = '0;
    #1 chk("fwd_x0", int'(forward_E), 0);
    step(); rs_E = {5'd3, 5'd5}; rd_W = 5'd3; regwrite_M = 1'b1;
    #1 chk("fwd_mixed", int'(forward_E), 'b0110);

    step(); idle(); load_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd7; rs_D = {5'd7, 5'd0};
    #1 chk("lu_stall_F", int'(stall_F), 1);
    chk("lu_stall_D", int'(stall_D), 1);
    chk("lu_flush_E", int'(flush_E), 1);
    chk("lu_flush_D", int'(flush_D), 0);
    step(); idle(); rs_D = {5'd7, 5'd0};
    #1 chk("lu_one_cycle", int'(stall_D), 0);
    step(); load_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd0; rs_D = '0;
    #1 chk("lu_x0", int'(stall_D), 0);
    chk("lu_x0_flush", int'(flush_E), 0);
    step(); idle(); load_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd7; regwrite_D = 1'b1; rd_D = 5'd7;
    #1 chk("lu_rd_only", int'(stall_D), 0);

    step(); idle(); load_E = 1'b1; regwrite_E = 1'b1; rd_E = 5'd7; rs_D = {5'd0, 5'd7}; pcsrc_E = 1'b1;
    #1 chk("br_stall_D", int'(stall_D), 0);
    chk("br_stall_F", int'(stall_F), 0);
    chk("br_flush_D", int'(flush_D), 1);
    chk("br_flush_E", int'(flush_E), 1);

    step(); idle(); mc_issue_E = 1'b1; rd_E = 5'd9; regwrite_E = 1'b1; rs_D = {5'd0, 5'd9};
    #1 chk("sb_inflight", int'(stall_D), 1);
    chk("sb_cnt0", int'(mc_count), 0);
    step(); idle(); rs_D = {5'd0, 5'd9};
    #1 chk("sb_cnt1", int'(mc_count), 1);
    chk("sb_busy_stall", int'(stall_D), 1);
    repeat (3) step();
    step(); rs_D = '0; regwrite_D = 1'b1; rd_D = 5'd9;
    #1 chk("sb_waw", int'(stall_D), 1);
    step(); rs_D = {5'd0, 5'd9}; regwrite_D = 1'b0; rd_D = '0; mc_done = 1'b1; mc_rd = 5'd9;
    #1 chk("sb_done_cycle", int'(stall_D), 1);
    step(); mc_done = 1'b0; mc_rd = '0;
    #1 chk("sb_release", int'(stall_D), 0);
    chk("sb_cnt_back", int'(mc_count), 0);

    for (int i = 1; i <= 4; i++) begin
      step(); idle(); mc_issue_E = 1'b1; rd_E = 5'(i); mc_op_D = 1'b1;
      #1;
      if (i == 3) chk("cap_below", int'(stall_D), 0);
      if (i == 4) chk("cap_issue_edge", int'(stall_D), 1);
    end
    step(); idle(); mc_op_D = 1'b1;
    #1 chk("cap_full", int'(mc_count), 4);
    chk("cap_stall", int'(stall_D), 1);
    step(); idle(); mc_issue_E = 1'b1; rd_E = 5'd5; mc_done = 1'b1; mc_rd = 5'd1;
    step(); idle();
    #1 chk("cap_swap", int'(mc_count), 4);
    step(); mc_done = 1'b1; mc_rd = 5'd20;
    step(); idle();
    #1 chk("cap_spurious", int'(mc_count), 4);
    step(); mc_done = 1'b1; mc_rd = 5'd0;
    step(); idle(); mc_done = 1'b1; mc_rd = 5'd2;
    step(); idle();
    #1 chk("cap_done", int'(mc_count), 3);

    rs_D = {5'd0, 5'd3};
    #1 chk("pre_rst_stall", int'(stall_D), 1);
    #1 rst_n = 1'b0;
    #1 chk("arst_count", int'(mc_count), 0);
    chk("arst_busy", int'(stall_D), 0);
    step(); rst_n = 1'b1; mc_done = 1'b1; mc_rd = 5'd3;
    step(); idle();
    #1 chk("post_rst_done", int'(mc_count), 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
